// File: rtl/filter_stream_bridge.sv
// Bridges the resampling filter's four-phase req/ack sample ports to valid/ready streams.
// An input FIFO answers filter input requests; an output FIFO absorbs filter output samples.
module filter_stream_bridge #(
  parameter int DWIDTH    = 16,
  parameter int DEPTH     = 8,
  parameter int DEPTH_LOG = 3,
  parameter int SWIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [0:DWIDTH-1]    s_data,
  input  logic                 f_req_in,
  output logic                 f_ack_in,
  output logic [0:DWIDTH-1]    f_data_in,
  input  logic                 f_req_out,
  output logic                 f_ack_out,
  input  logic [0:DWIDTH-1]    f_data_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [0:DWIDTH-1]    m_data,
  output logic [DEPTH_LOG:0]   in_count,
  output logic [DEPTH_LOG:0]   out_count,
  output logic [SWIDTH-1:0]    in_starve,
  output logic [SWIDTH-1:0]    out_block
);

  localparam logic [0:0] IN_IDLE  = 1'b0;
  localparam logic [0:0] IN_ACK   = 1'b1;
  localparam logic [0:0] OUT_IDLE = 1'b0;
  localparam logic [0:0] OUT_ACK  = 1'b1;

  localparam logic [DEPTH_LOG:0]   FULL_CNT = DEPTH[DEPTH_LOG:0];
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);
  localparam logic [SWIDTH-1:0]    STALL_ONE = SWIDTH'(1);

  logic [0:DWIDTH-1]    in_mem_q  [DEPTH];
  logic [0:DWIDTH-1]    out_mem_q [DEPTH];

  logic [DEPTH_LOG-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [DEPTH_LOG-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [DEPTH_LOG:0]   in_count_q, in_count_d, out_count_q, out_count_d;
  logic [0:0]           in_state_q, in_state_d, out_state_q, out_state_d;
  logic [0:DWIDTH-1]    f_data_in_q, f_data_in_d;
  logic [SWIDTH-1:0]    in_starve_q, in_starve_d, out_block_q, out_block_d;

  logic in_push, in_pop, in_empty, out_write, out_pop, out_full;

  assign in_empty  = (in_count_q == '0);
  assign out_full  = (out_count_q == FULL_CNT);
  assign s_ready   = !rst && (in_count_q != FULL_CNT);
  assign m_valid   = (out_count_q != '0);
  assign in_push   = s_valid && s_ready;
  assign in_pop    = (in_state_q == IN_IDLE) && f_req_in && !in_empty;
  assign out_write = (out_state_q == OUT_IDLE) && f_req_out && !out_full;
  assign out_pop   = m_valid && m_ready;

  assign f_ack_in  = (in_state_q == IN_ACK);
  assign f_ack_out = (out_state_q == OUT_ACK);
  assign f_data_in = f_data_in_q;
  assign m_data    = m_valid ? out_mem_q[out_rd_ptr_q] : '0;
  assign in_count  = in_count_q;
  assign out_count = out_count_q;
  assign in_starve = in_starve_q;
  assign out_block = out_block_q;

  always_comb begin
    in_wr_ptr_d = in_push ? in_wr_ptr_q + PTR_ONE : in_wr_ptr_q;
    in_rd_ptr_d = in_pop  ? in_rd_ptr_q + PTR_ONE : in_rd_ptr_q;
    in_count_d  = in_count_q;
    case ({in_push, in_pop})
      2'b10:   in_count_d = in_count_q + CNT_ONE;
      2'b01:   in_count_d = in_count_q - CNT_ONE;
      default: in_count_d = in_count_q;
    endcase
    f_data_in_d = in_pop ? in_mem_q[in_rd_ptr_q] : f_data_in_q;
    in_state_d  = in_state_q;
    case (in_state_q)
      IN_IDLE: if (in_pop) in_state_d = IN_ACK;
      default: if (!f_req_in) in_state_d = IN_IDLE;
    endcase
    in_starve_d = in_starve_q;
    if ((in_state_q == IN_IDLE) && f_req_in && in_empty && (in_starve_q != '1))
      in_starve_d = in_starve_q + STALL_ONE;
  end

  // A full FIFO defers the write even when a pop frees space this cycle.
  always_comb begin
    out_wr_ptr_d = out_write ? out_wr_ptr_q + PTR_ONE : out_wr_ptr_q;
    out_rd_ptr_d = out_pop   ? out_rd_ptr_q + PTR_ONE : out_rd_ptr_q;
    out_count_d  = out_count_q;
    case ({out_write, out_pop})
      2'b10:   out_count_d = out_count_q + CNT_ONE;
      2'b01:   out_count_d = out_count_q - CNT_ONE;
      default: out_count_d = out_count_q;
    endcase
    out_state_d = out_state_q;
    case (out_state_q)
      OUT_IDLE: if (out_write) out_state_d = OUT_ACK;
      default:  if (!f_req_out) out_state_d = OUT_IDLE;
    endcase
    out_block_d = out_block_q;
    if ((out_state_q == OUT_IDLE) && f_req_out && out_full && (out_block_q != '1))
      out_block_d = out_block_q + STALL_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      in_count_q   <= '0;
      in_state_q   <= IN_IDLE;
      f_data_in_q  <= '0;
      in_starve_q  <= '0;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_count_q  <= '0;
      out_state_q  <= OUT_IDLE;
      out_block_q  <= '0;
    end else begin
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_count_q   <= in_count_d;
      in_state_q   <= in_state_d;
      f_data_in_q  <= f_data_in_d;
      in_starve_q  <= in_starve_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_count_q  <= out_count_d;
      out_state_q  <= out_state_d;
      out_block_q  <= out_block_d;
    end
  end

  // Storage needs no reset; occupancy counters alone decide what is valid.
  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_ptr_q] <= s_data;
    if (out_write) out_mem_q[out_wr_ptr_q] <= f_data_out;
  end

endmodule

// File: tb/tb_filter_stream_bridge.sv
// Directed self-checking bench for filter_stream_bridge.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_filter_stream_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [0:15] s_data;
  logic        f_req_in;
  logic        f_ack_in;
  logic [0:15] f_data_in;
  logic        f_req_out;
  logic        f_ack_out;
  logic [0:15] f_data_out;
  logic        m_valid;
  logic        m_ready;
  logic [0:15] m_data;
  logic [3:0]  in_count;
  logic [3:0]  out_count;
  logic [15:0] in_starve;
  logic [15:0] out_block;

  int checks = 0;
  int fails  = 0;

  filter_stream_bridge #(.DWIDTH(16), .DEPTH(8), .DEPTH_LOG(3), .SWIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .f_req_in(f_req_in), .f_ack_in(f_ack_in), .f_data_in(f_data_in),
    .f_req_out(f_req_out), .f_ack_out(f_ack_out), .f_data_out(f_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .in_count(in_count), .out_count(out_count),
    .in_starve(in_starve), .out_block(out_block)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic [0:15] sd, input logic rq_in,
                               input logic rq_out, input logic [0:15] fd_out, input logic mr);
    s_valid    = sv;
    s_data     = sd;
    f_req_in   = rq_in;
    f_req_out  = rq_out;
    f_data_out = fd_out;
    m_ready    = mr;
  endtask

  task automatic pushSample(input logic [0:15] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  // Full four-phase read: wait for ack, hold req two more cycles, then release.
  task automatic filterRead(input logic [0:15] expected);
    int waited = 0;
    f_req_in = 1'b1;
    tick();
    while (!f_ack_in && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("in_ack_seen", {31'd0, f_ack_in}, 32'd1);
    checkOutput("in_data", {16'd0, f_data_in}, {16'd0, expected});
    tick();
    tick();
    checkOutput("in_data_hold", {16'd0, f_data_in}, {16'd0, expected});
    f_req_in = 1'b0;
    tick();
    checkOutput("in_ack_drop", {31'd0, f_ack_in}, 32'd0);
  endtask

  task automatic filterWrite(input logic [0:15] d);
    f_req_out  = 1'b1;
    f_data_out = d;
    tick();
    checkOutput("out_ack", {31'd0, f_ack_out}, 32'd1);
    f_req_out = 1'b0;
    tick();
    checkOutput("out_ack_drop", {31'd0, f_ack_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("rst_ack_in", {31'd0, f_ack_in}, 32'd0);
    checkOutput("rst_data_in", {16'd0, f_data_in}, 32'd0);
    checkOutput("rst_ack_out", {31'd0, f_ack_out}, 32'd0);
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", {16'd0, m_data}, 32'd0);
    checkOutput("rst_counts", {24'd0, in_count, out_count}, 32'd0);
    checkOutput("rst_stalls", {in_starve, out_block}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    // In-order delivery of boundary sample values
    pushSample(16'h0001);
    pushSample(16'h7FFF);
    pushSample(16'h8000);
    checkOutput("in_count_3", {28'd0, in_count}, 32'd3);
    filterRead(16'h0001);
    filterRead(16'h7FFF);
    filterRead(16'h8000);
    checkOutput("in_count_0", {28'd0, in_count}, 32'd0);
    checkOutput("starve_none", {16'd0, in_starve}, 32'd0);

    // Starvation: five requested cycles with an empty FIFO, the last one carrying the push
    f_req_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    s_valid = 1'b1;
    s_data  = 16'h1234;
    tick();
    s_valid = 1'b0;
    checkOutput("starve_5", {16'd0, in_starve}, 32'd5);
    checkOutput("starve_no_ack_yet", {31'd0, f_ack_in}, 32'd0);
    tick();
    checkOutput("starve_ack", {31'd0, f_ack_in}, 32'd1);
    checkOutput("starve_data", {16'd0, f_data_in}, 32'h1234);
    checkOutput("starve_hold", {16'd0, in_starve}, 32'd5);
    f_req_in = 1'b0;
    tick();

    // Fill the input FIFO (pointers wrap) and refuse a ninth sample
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 16'hA000 + 16'(i);
      tick();
    end
    checkOutput("full_count", {28'd0, in_count}, 32'd8);
    checkOutput("full_s_ready", {31'd0, s_ready}, 32'd0);
    s_data = 16'hBEEF;
    tick();
    s_valid = 1'b0;
    checkOutput("full_no_push", {28'd0, in_count}, 32'd8);
    f_req_in = 1'b1;
    tick();
    checkOutput("full_pop_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("full_pop_data", {16'd0, f_data_in}, 32'hA000);
    f_req_in = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) filterRead(16'hA000 + 16'(i));
    checkOutput("drain_in_count", {28'd0, in_count}, 32'd0);

    // Output FIFO fill, blocked ninth request, deferred write after a pop
    for (int i = 0; i < 8; i++) filterWrite(16'h0100 + 16'(i));
    checkOutput("out_count_8", {28'd0, out_count}, 32'd8);
    checkOutput("out_head", {16'd0, m_data}, 32'h0100);
    f_req_out  = 1'b1;
    f_data_out = 16'h0108;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("block_no_ack", {31'd0, f_ack_out}, 32'd0);
    checkOutput("block_3", {16'd0, out_block}, 32'd3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("deferred_no_ack", {31'd0, f_ack_out}, 32'd0);
    checkOutput("deferred_count", {28'd0, out_count}, 32'd7);
    checkOutput("deferred_head", {16'd0, m_data}, 32'h0101);
    tick();
    checkOutput("deferred_ack", {31'd0, f_ack_out}, 32'd1);
    checkOutput("deferred_full", {28'd0, out_count}, 32'd8);
    checkOutput("block_4", {16'd0, out_block}, 32'd4);
    f_req_out = 1'b0;
    tick();
    m_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      checkOutput("m_data_order", {16'd0, m_data}, {16'd0, 16'h0100 + 16'(i)});
      tick();
    end
    m_ready = 1'b0;
    checkOutput("out_drained", {31'd0, m_valid}, 32'd0);

    // Reset while acknowledging with data in both FIFOs
    pushSample(16'h0A0A);
    pushSample(16'h0B0B);
    for (int i = 0; i < 4; i++) filterWrite(16'h0200 + 16'(i));
    checkOutput("pre_rst_out_count", {28'd0, out_count}, 32'd4);
    f_req_in = 1'b1;
    tick();
    checkOutput("pre_rst_ack", {31'd0, f_ack_in}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_ack", {31'd0, f_ack_in}, 32'd0);
    checkOutput("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("mid_rst_counts", {24'd0, in_count, out_count}, 32'd0);
    checkOutput("mid_rst_stalls", {in_starve, out_block}, 32'd0);
    f_req_in = 1'b0;
    rst = 1'b0;
    tick();
    pushSample(16'h5555);
    filterRead(16'h5555);
    filterWrite(16'h0AAA);
    checkOutput("post_rst_m_data", {16'd0, m_data}, 32'h0AAA);

    // Long request hold yields exactly one pop
    pushSample(16'h1111);
    pushSample(16'h2222);
    f_req_in = 1'b1;
    tick();
    checkOutput("hold_ack", {31'd0, f_ack_in}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("hold_still_ack", {31'd0, f_ack_in}, 32'd1);
    checkOutput("hold_one_pop", {28'd0, in_count}, 32'd1);
    checkOutput("hold_data", {16'd0, f_data_in}, 32'h1111);
    f_req_in = 1'b0;
    tick();
    filterRead(16'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
